cam_table_controller: RTL and testbench
=======================================

// Module: cam_table_controller
// PURPOSE
//  Owns a SLOTS-entry value table with per-entry valid bits and sequences all access to it through one
//  valid/ready request port. It serves LOOKUP, INSERT, REMOVE and CLEAR requests.
//  The associative compare is done by an internal matching_encoder instance fed by the table registers.
//  It is used as a tag/ID tracking table (e.g. outstanding-miss or in-flight-ID tracking).
// PARAMETERS
//  INDEX_WIDTH  2                 log2 of the number of table slots
//  VALUE_WIDTH  4                 width of each stored value
//  SLOTS        1<<INDEX_WIDTH    number of slots (derived; do not override)
// PORTS
//  clock         in   1              single clock; all state updates on rising edge
//  reset         in   1              synchronous, active-high
//  req_valid     in   1              request present
//  req_ready     out  1              request accepted on req_valid && req_ready
//  req_op        in   2              00 LOOKUP, 01 INSERT, 10 REMOVE, 11 CLEAR
//  req_value     in   VALUE_WIDTH    value operand; ignored for CLEAR
//  resp_valid    out  1              response present
//  resp_ready    in   1              response consumed on resp_valid && resp_ready
//  resp_hit      out  1              value was already present in a valid slot
//  resp_full     out  1              INSERT refused: table full and value absent
//  resp_index    out  INDEX_WIDTH    slot index of the hit or of the new insert, else 0
//  occupancy     out  INDEX_WIDTH+1  number of valid slots
//  full          out  1              occupancy == SLOTS
//  empty         out  1              occupancy == 0
// BEHAVIOUR
//  Reset (synchronous):
//   - All valids and values are set to 0. The FSM goes to IDLE and the clear pointer to 0.
//   - resp_valid/hit/full/index = 0, occupancy = 0, empty = 1, full = 0.
//   - req_ready = 0 while reset is high.
//   - Reset overrides everything, including a CLEAR in progress.
//  FSM states:
//   - IDLE: serves requests.
//   - CLEARING: walks clear_ptr from 0 to SLOTS-1, clearing one valid bit per cycle.
//  Handshake:
//   - req_ready = (state==IDLE) && (!resp_valid || resp_ready). This is combinational, with no comb path from req_valid.
//   - One response register. A response is held stable while resp_valid && !resp_ready.
//   - Back-to-back requests give one op per cycle when resp_ready stays high.
//  LOOKUP / INSERT / REMOVE:
//   - Latency is 1: the table is updated at the accept edge, and resp_valid=1 the next cycle.
//   - A request sees every table update made by earlier accepted requests.
//   - LOOKUP: hit = encoder match; index = encoder index; table unchanged.
//   - INSERT, value present: hit=1, index=existing slot, no write. Duplicates are never created, so a match is unique.
//   - INSERT, absent and not full: write the lowest-index invalid slot and set its valid; hit=0, full=0, index=that slot.
//   - INSERT, absent and full: resp_full=1, hit=0, index=0; table unchanged.
//   - REMOVE, present: clear that slot's valid (value bits keep their contents); hit=1, index=slot.
//   - REMOVE, absent: hit=0, index=0; no change.
//   - resp_full is 0 for every op except a refused INSERT.
//  CLEAR:
//   - Accept moves the FSM to CLEARING with clear_ptr=0. req_ready=0 throughout.
//   - Each edge clears valid[clear_ptr] and increments clear_ptr.
//   - The edge that clears slot SLOTS-1 returns the FSM to IDLE and sets resp_valid=1 with hit=0, full=0, index=0.
//   - So resp_valid rises exactly SLOTS edges after the accepting edge.
//  Occupancy:
//   - Updated on the same edge as the valid bit change: +1 on insert, -1 on remove, -1 per previously valid slot cleared.
//   - It never exceeds SLOTS and never wraps below 0. full and empty are derived from it.
// TESTING  (INDEX_WIDTH=2, VALUE_WIDTH=4, resp_ready=1 unless stated)
//  1. Reset 2 cycles then release -> empty=1, full=0, occupancy=0, resp_valid=0; req_ready=1 on the first cycle after reset.
//  2. INSERT 4'h4,4'h3,4'h2,4'h1 back-to-back -> resp index 0,1,2,3 with hit=0; then full=1, occupancy=4.
//     Then LOOKUP 4'h3 -> hit=1, idx=1. LOOKUP 4'h0 -> hit=0.
//  3. Full table: INSERT 4'h5 -> resp_full=1, occupancy stays 4. INSERT 4'h3 -> hit=1, idx=1, resp_full=0.
//  4. REMOVE 4'h1 -> hit=1, idx=3, occupancy=3. LOOKUP 4'h1 -> hit=0. INSERT 4'h7 -> hit=0, idx=3.
//  5. Backpressure: hold resp_ready=0 for 5 cycles with a response pending -> req_ready=0 and resp_* stable all 5 cycles.
//     Raise resp_ready -> the next request is accepted in the same cycle.
//  6. CLEAR on a full table -> req_ready=0 for 4 cycles; resp_valid rises on the 4th edge with empty=1.
//     Repeat, asserting reset after 2 edges -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/cam_table_controller.sv
// Tag/ID tracking table. It has SLOTS value registers, each with a valid bit.
// All access goes through a single valid/ready request port and a single
// response register. The associative search is done by matching_encoder.

module matching_encoder #(
    parameter int ENTRIES     = 4,
    parameter int WIDTH       = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic [ENTRIES*WIDTH-1:0] entry_values,
    input  logic [ENTRIES-1:0]       entry_valid,
    input  logic [WIDTH-1:0]         key,
    output logic                     match,
    output logic [INDEX_WIDTH-1:0]   match_index
);

    // Lowest-index valid entry whose value equals key. Index is 0 on a miss.
    always_comb begin
        match       = 1'b0;
        match_index = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!match && entry_valid[i] && (entry_values[i*WIDTH +: WIDTH] == key)) begin
                match       = 1'b1;
                match_index = INDEX_WIDTH'(i);
            end
        end
    end

endmodule

module cam_table_controller #(
    parameter int INDEX_WIDTH = 2,
    parameter int VALUE_WIDTH = 4,
    parameter int SLOTS       = 1 << INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [VALUE_WIDTH-1:0] req_value,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_hit,
    output logic                   resp_full,
    output logic [INDEX_WIDTH-1:0] resp_index,
    output logic [INDEX_WIDTH:0]   occupancy,
    output logic                   full,
    output logic                   empty
);

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_REMOVE = 2'b10,
        OP_CLEAR  = 2'b11
    } op_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEARING
    } state_t;

    localparam logic [INDEX_WIDTH:0]   OCC_ONE  = (INDEX_WIDTH+1)'(1);
    localparam logic [INDEX_WIDTH:0]   OCC_FULL = (INDEX_WIDTH+1)'(SLOTS);
    localparam logic [INDEX_WIDTH-1:0] PTR_ONE  = INDEX_WIDTH'(1);

    state_t                   state;
    logic [INDEX_WIDTH-1:0]   clear_ptr;
    logic [VALUE_WIDTH-1:0]   values [SLOTS];
    logic [SLOTS-1:0]         valid;
    logic [SLOTS*VALUE_WIDTH-1:0] values_flat;

    logic                     match;
    logic [INDEX_WIDTH-1:0]   match_index;
    logic                     has_free;
    logic [INDEX_WIDTH-1:0]   free_index;
    logic                     accept;

    // Flatten the value registers into the encoder's bus.
    always_comb begin
        values_flat = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            values_flat[i*VALUE_WIDTH +: VALUE_WIDTH] = values[i];
        end
    end

    matching_encoder #(
        .ENTRIES     (SLOTS),
        .WIDTH       (VALUE_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_match (
        .entry_values (values_flat),
        .entry_valid  (valid),
        .key          (req_value),
        .match        (match),
        .match_index  (match_index)
    );

    // Lowest-index invalid slot. This is the insert target.
    always_comb begin
        has_free   = 1'b0;
        free_index = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!has_free && !valid[i]) begin
                has_free   = 1'b1;
                free_index = INDEX_WIDTH'(i);
            end
        end
    end

    // Ready depends only on registered state, the consumer's ready and reset.
    // It never depends on req_valid.
    always_comb begin
        req_ready = !reset && (state == ST_IDLE) && (!resp_valid || resp_ready);
        accept    = req_valid && req_ready;
        full      = (occupancy == OCC_FULL);
        empty     = (occupancy == '0);
    end

    // Table, occupancy, FSM and response register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            clear_ptr  <= '0;
            valid      <= '0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                values[i] <= '0;
            end
            occupancy  <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_full  <= 1'b0;
            resp_index <= '0;
        end else begin
            if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        resp_hit   <= 1'b0;
                        resp_full  <= 1'b0;
                        resp_index <= '0;
                        case (op_t'(req_op))
                            OP_LOOKUP: begin
                                resp_valid <= 1'b1;
                                resp_hit   <= match;
                                resp_index <= match_index;
                            end
                            OP_INSERT: begin
                                resp_valid <= 1'b1;
                                if (match) begin
                                    resp_hit   <= 1'b1;
                                    resp_index <= match_index;
                                end else if (!has_free) begin
                                    resp_full  <= 1'b1;
                                end else begin
                                    values[free_index] <= req_value;
                                    valid[free_index]  <= 1'b1;
                                    occupancy          <= occupancy + OCC_ONE;
                                    resp_index         <= free_index;
                                end
                            end
                            OP_REMOVE: begin
                                resp_valid <= 1'b1;
                                if (match) begin
                                    valid[match_index] <= 1'b0;
                                    occupancy          <= occupancy - OCC_ONE;
                                    resp_hit           <= 1'b1;
                                    resp_index         <= match_index;
                                end
                            end
                            OP_CLEAR: begin
                                state     <= ST_CLEARING;
                                clear_ptr <= '0;
                            end
                        endcase
                    end
                end
                ST_CLEARING: begin
                    valid[clear_ptr] <= 1'b0;
                    if (valid[clear_ptr]) begin
                        occupancy <= occupancy - OCC_ONE;
                    end
                    if (&clear_ptr) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b1;
                        resp_hit   <= 1'b0;
                        resp_full  <= 1'b0;
                        resp_index <= '0;
                    end else begin
                        clear_ptr <= clear_ptr + PTR_ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_table_controller.sv
// Directed, self-checking bench for cam_table_controller (4 slots, 4-bit values).
module tb_cam_table_controller;

    localparam logic [1:0] OP_L = 2'b00;
    localparam logic [1:0] OP_I = 2'b01;
    localparam logic [1:0] OP_R = 2'b10;
    localparam logic [1:0] OP_C = 2'b11;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_value;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_hit;
    logic       resp_full;
    logic [1:0] resp_index;
    logic [2:0] occupancy;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0] op;
        logic [3:0] value;
        logic       hit;
        logic       rfull;
        logic [1:0] idx;
        logic [2:0] occ;
    } vec_t;

    vec_t vecs [15];

    cam_table_controller #(
        .INDEX_WIDTH (2),
        .VALUE_WIDTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_value  (req_value),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hit   (resp_hit),
        .resp_full  (resp_full),
        .resp_index (resp_index),
        .occupancy  (occupancy),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge. It presents one request, which must be
    // accepted on the next rising edge. It then checks the response at the
    // following falling edge. req_valid stays high so that the next call runs
    // back to back.
    task automatic apply(input string tag, input logic [1:0] op, input logic [3:0] value,
                         input logic hit, input logic rfull, input logic [1:0] idx,
                         input logic [2:0] occ);
        req_valid = 1'b1;
        req_op    = op;
        req_value = value;
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, " resp_hit"},   32'(resp_hit),   32'(hit));
        check({tag, " resp_full"},  32'(resp_full),  32'(rfull));
        check({tag, " resp_index"}, 32'(resp_index), 32'(idx));
        check({tag, " occupancy"},  32'(occupancy),  32'(occ));
        check({tag, " full"},       32'(full),       32'(occ == 3'd4));
        check({tag, " empty"},      32'(empty),      32'(occ == 3'd0));
    endtask

    initial begin
        vecs[0]  = '{OP_L, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0};
        vecs[1]  = '{OP_I, 4'h4, 1'b0, 1'b0, 2'd0, 3'd1};
        vecs[2]  = '{OP_I, 4'h3, 1'b0, 1'b0, 2'd1, 3'd2};
        vecs[3]  = '{OP_I, 4'h2, 1'b0, 1'b0, 2'd2, 3'd3};
        vecs[4]  = '{OP_I, 4'h1, 1'b0, 1'b0, 2'd3, 3'd4};
        vecs[5]  = '{OP_L, 4'h3, 1'b1, 1'b0, 2'd1, 3'd4};
        vecs[6]  = '{OP_L, 4'h0, 1'b0, 1'b0, 2'd0, 3'd4};
        vecs[7]  = '{OP_I, 4'h5, 1'b0, 1'b1, 2'd0, 3'd4};
        vecs[8]  = '{OP_I, 4'h3, 1'b1, 1'b0, 2'd1, 3'd4};
        vecs[9]  = '{OP_R, 4'h1, 1'b1, 1'b0, 2'd3, 3'd3};
        vecs[10] = '{OP_L, 4'h1, 1'b0, 1'b0, 2'd0, 3'd3};
        vecs[11] = '{OP_I, 4'h7, 1'b0, 1'b0, 2'd3, 3'd4};
        vecs[12] = '{OP_R, 4'h9, 1'b0, 1'b0, 2'd0, 3'd4};
        vecs[13] = '{OP_R, 4'h4, 1'b1, 1'b0, 2'd0, 3'd3};
        vecs[14] = '{OP_I, 4'h4, 1'b0, 1'b0, 2'd0, 3'd4};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = OP_L;
        req_value  = '0;
        resp_ready = 1'b1;

        // Hold reset for two cycles, then release it.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("req_ready in reset", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst req_ready",  32'(req_ready),  32'd1);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst occupancy",  32'(occupancy),  32'd0);
        check("rst empty",      32'(empty),      32'd1);
        check("rst full",       32'(full),       32'd0);

        // Back-to-back table vectors.
        for (int i = 0; i < 15; i++) begin
            apply($sformatf("v%0d", i), vecs[i].op, vecs[i].value, vecs[i].hit,
                  vecs[i].rfull, vecs[i].idx, vecs[i].occ);
        end
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("drain resp_valid", 32'(resp_valid), 32'd0);

        // Backpressure. LOOKUP 7 is accepted while resp_ready is low.
        req_valid  = 1'b1;
        req_op     = OP_L;
        req_value  = 4'h7;
        resp_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_value = 4'h2;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d req_ready", c),  32'(req_ready),  32'd0);
            check($sformatf("bp%0d resp_valid", c), 32'(resp_valid), 32'd1);
            check($sformatf("bp%0d resp_hit", c),   32'(resp_hit),   32'd1);
            check($sformatf("bp%0d resp_index", c), 32'(resp_index), 32'd3);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        #1;
        check("bp release req_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        check("bp next resp_valid", 32'(resp_valid), 32'd1);
        check("bp next resp_hit",   32'(resp_hit),   32'd1);
        check("bp next resp_index", 32'(resp_index), 32'd2);

        // CLEAR on a full table.
        check("pre-clear full", 32'(full), 32'd1);
        req_op = OP_C;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("clr%0d req_ready", c),  32'(req_ready),  32'd0);
            check($sformatf("clr%0d resp_valid", c), 32'(resp_valid), 32'd0);
            check($sformatf("clr%0d occupancy", c),  32'(occupancy),  32'(4 - c));
            @(negedge clock);
        end
        check("clr done resp_valid", 32'(resp_valid), 32'd1);
        check("clr done resp_hit",   32'(resp_hit),   32'd0);
        check("clr done resp_full",  32'(resp_full),  32'd0);
        check("clr done resp_index", 32'(resp_index), 32'd0);
        check("clr done empty",      32'(empty),      32'd1);
        check("clr done req_ready",  32'(req_ready),  32'd1);

        // Refill the table, then start a CLEAR and cut it short with reset.
        apply("rf0", OP_I, 4'hA, 1'b0, 1'b0, 2'd0, 3'd1);
        apply("rf1", OP_I, 4'hB, 1'b0, 1'b0, 2'd1, 3'd2);
        apply("rf2", OP_I, 4'hC, 1'b0, 1'b0, 2'd2, 3'd3);
        apply("rf3", OP_I, 4'hD, 1'b0, 1'b0, 2'd3, 3'd4);
        req_op = OP_C;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("mid-clear occupancy", 32'(occupancy), 32'd2);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst2 resp_valid", 32'(resp_valid), 32'd0);
        check("rst2 resp_hit",   32'(resp_hit),   32'd0);
        check("rst2 resp_full",  32'(resp_full),  32'd0);
        check("rst2 resp_index", 32'(resp_index), 32'd0);
        check("rst2 occupancy",  32'(occupancy),  32'd0);
        check("rst2 empty",      32'(empty),      32'd1);
        check("rst2 full",       32'(full),       32'd0);
        check("rst2 req_ready",  32'(req_ready),  32'd0);
        reset = 1'b0;
        #1;
        check("rst2 release req_ready", 32'(req_ready), 32'd1);
        // Slot 3 was never reached by the walk. Reset must still invalidate it.
        apply("post-rst", OP_L, 4'hD, 1'b0, 1'b0, 2'd0, 3'd0);
        req_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
